// File: rtl/mdu_hilo_if.sv
// Execute-stage multiply/divide request/response bundle.
interface mdu_hilo_if;
    logic        Start;
    logic [3:0]  MDUOP;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  ReadHILO;
    logic        Busy;
    logic [31:0] Result;

    // Pipeline side: issues ops and reads HI/LO
    modport master (
        output Start, MDUOP, A, B, ReadHILO,
        input  Busy, Result
    );

    // Unit side
    modport slave (
        input  Start, MDUOP, A, B, ReadHILO,
        output Busy, Result
    );
endinterface

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO registers.
// Results are computed at accept time, held as pending, and committed
// to HI/LO when the latency counter expires.
module mdu_hilo #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       rst,
    mdu_hilo_if.slave  bus
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam logic [1:0] RD_HI = 2'd1;
    localparam logic [1:0] RD_LO = 2'd2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   hi, hi_n;
    logic [31:0]   lo, lo_n;
    logic [31:0]   pend_hi, pend_hi_n;
    logic [31:0]   pend_lo, pend_lo_n;
    logic          pend_wr, pend_wr_n;

    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic [31:0]   mag_a, mag_b;
    logic [31:0]   sq_mag, sr_mag;
    logic [31:0]   sdiv_q, sdiv_r;
    logic [31:0]   udiv_q, udiv_r;
    logic          b_zero;

    // Arithmetic datapath: products and quotients of the current operands
    always_comb begin
        prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
        prod_u = {32'd0, bus.A} * {32'd0, bus.B};
        b_zero = (bus.B == 32'd0);
        mag_a  = bus.A[31] ? (32'd0 - bus.A) : bus.A;
        mag_b  = bus.B[31] ? (32'd0 - bus.B) : bus.B;
        // Divider outputs are don't-care when B is zero; commit is suppressed then
        sq_mag = b_zero ? 32'd0 : (mag_a / mag_b);
        sr_mag = b_zero ? 32'd0 : (mag_a % mag_b);
        udiv_q = b_zero ? 32'd0 : (bus.A / bus.B);
        udiv_r = b_zero ? 32'd0 : (bus.A % bus.B);
        // Quotient truncates toward zero; remainder follows the dividend sign
        sdiv_q = (bus.A[31] ^ bus.B[31]) ? (32'd0 - sq_mag) : sq_mag;
        sdiv_r = bus.A[31] ? (32'd0 - sr_mag) : sr_mag;
    end

    // Next-state logic: accept in idle, count down and commit while busy
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hi_n      = hi;
        lo_n      = lo;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        pend_wr_n = pend_wr;

        case (state)
            S_IDLE: begin
                if (bus.Start) begin
                    case (bus.MDUOP)
                        OP_MULT: begin
                            pend_hi_n = prod_s[63:32];
                            pend_lo_n = prod_s[31:0];
                            pend_wr_n = 1'b1;
                            cnt_n     = CW'(MULT_CYCLES);
                            state_n   = S_BUSY;
                        end
                        OP_MULTU: begin
                            pend_hi_n = prod_u[63:32];
                            pend_lo_n = prod_u[31:0];
                            pend_wr_n = 1'b1;
                            cnt_n     = CW'(MULT_CYCLES);
                            state_n   = S_BUSY;
                        end
                        OP_DIV: begin
                            pend_hi_n = sdiv_r;
                            pend_lo_n = sdiv_q;
                            pend_wr_n = ~b_zero;
                            cnt_n     = CW'(DIV_CYCLES);
                            state_n   = S_BUSY;
                        end
                        OP_DIVU: begin
                            pend_hi_n = udiv_r;
                            pend_lo_n = udiv_q;
                            pend_wr_n = ~b_zero;
                            cnt_n     = CW'(DIV_CYCLES);
                            state_n   = S_BUSY;
                        end
                        OP_MTHI: hi_n = bus.A;
                        OP_MTLO: lo_n = bus.A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                // New requests are ignored here; the in-flight op runs to completion
                if (cnt == CW'(1)) begin
                    if (pend_wr) begin
                        hi_n = pend_hi;
                        lo_n = pend_lo;
                    end
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State register with synchronous reset that discards any in-flight op
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            hi      <= hi_n;
            lo      <= lo_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
            pend_wr <= pend_wr_n;
        end
    end

    assign bus.Busy = (state == S_BUSY);

    // Read port: committed HI/LO only, no bypass of pending results
    always_comb begin
        case (bus.ReadHILO)
            RD_HI:   bus.Result = hi;
            RD_LO:   bus.Result = lo;
            default: bus.Result = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo.
module tb_mdu_hilo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mdu_hilo_if bus ();

    mdu_hilo #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] sel, output logic [31:0] val);
        bus.ReadHILO = sel;
        #1;
        val = bus.Result;
        bus.ReadHILO = 2'd0;
        #1;
    endtask

    task automatic chk_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] v;
        rd(2'd1, v);
        chk({tag, "_hi"}, v, ehi);
        rd(2'd2, v);
        chk({tag, "_lo"}, v, elo);
    endtask

    // Issue a multi-cycle op and check Busy for exactly ncyc cycles, then HI/LO
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int ncyc,
                          input logic [31:0] old_lo,
                          input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] v;
        bus.Start = 1'b1;
        bus.MDUOP = op;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.Start = 1'b0;
        bus.MDUOP = 4'd0;
        bus.A     = 32'h5555_AAAA;
        bus.B     = 32'h0000_0001;
        for (int i = 0; i < ncyc; i++) begin
            chk({tag, "_busy"}, 32'(bus.Busy), 32'd1);
            if (i == 0) begin
                rd(2'd2, v);
                chk({tag, "_old_lo"}, v, old_lo);
            end
            tick();
        end
        chk({tag, "_busy_fall"}, 32'(bus.Busy), 32'd0);
        chk_hilo(tag, ehi, elo);
    endtask

    initial begin
        logic [31:0] v;
        bus.Start    = 1'b0;
        bus.MDUOP    = 4'd0;
        bus.A        = 32'd0;
        bus.B        = 32'd0;
        bus.ReadHILO = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", 32'(bus.Busy), 32'd0);
        chk_hilo("reset", 32'd0, 32'd0);
        rd(2'd3, v);
        chk("read_none", v, 32'd0);

        // MTHI / MTLO are zero-latency and never raise Busy
        bus.Start = 1'b1; bus.MDUOP = 4'd5; bus.A = 32'h1234_5678;
        tick();
        bus.Start = 1'b0; bus.MDUOP = 4'd0;
        chk("mthi_busy", 32'(bus.Busy), 32'd0);
        rd(2'd1, v);
        chk("mfhi", v, 32'h1234_5678);
        bus.Start = 1'b1; bus.MDUOP = 4'd6; bus.A = 32'h9ABC_DEF0;
        tick();
        bus.Start = 1'b0; bus.MDUOP = 4'd0;
        chk("mtlo_busy", 32'(bus.Busy), 32'd0);
        chk_hilo("mtlo", 32'h1234_5678, 32'h9ABC_DEF0);

        // Undefined op with Start does nothing
        bus.Start = 1'b1; bus.MDUOP = 4'd9; bus.A = 32'hDEAD_BEEF;
        tick();
        bus.Start = 1'b0; bus.MDUOP = 4'd0;
        chk("undef_busy", 32'(bus.Busy), 32'd0);
        chk_hilo("undef", 32'h1234_5678, 32'h9ABC_DEF0);

        run_op("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h9ABC_DEF0,
               32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFA,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_m7_2", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_by0", 4'd4, 32'd7, 32'd0, 10, 32'hFFFF_FFFD,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'hFFFF_FFFD,
               32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFD,
               32'h0000_0000, 32'h8000_0000);
        run_op("divu_100_7", 4'd4, 32'd100, 32'd7, 10, 32'h8000_0000,
               32'h0000_0002, 32'h0000_000E);
        run_op("div_by0", 4'd3, 32'hFFFF_FF00, 32'd0, 10, 32'h0000_000E,
               32'h0000_0002, 32'h0000_000E);

        // MTLO issued mid-multiply is ignored
        bus.Start = 1'b1; bus.MDUOP = 4'd1; bus.A = 32'd3; bus.B = 32'd5;
        tick();
        bus.Start = 1'b0; bus.MDUOP = 4'd0;
        chk("ign_busy0", 32'(bus.Busy), 32'd1);
        tick();
        bus.Start = 1'b1; bus.MDUOP = 4'd6; bus.A = 32'h0000_00AA;
        chk("ign_busy1", 32'(bus.Busy), 32'd1);
        tick();
        bus.Start = 1'b0; bus.MDUOP = 4'd0;
        chk("ign_busy2", 32'(bus.Busy), 32'd1);
        rd(2'd2, v);
        chk("ign_lo_hold", v, 32'h0000_000E);
        tick();
        chk("ign_busy3", 32'(bus.Busy), 32'd1);
        tick();
        chk("ign_busy4", 32'(bus.Busy), 32'd1);
        tick();
        chk("ign_busy_fall", 32'(bus.Busy), 32'd0);
        chk_hilo("ign", 32'h0000_0000, 32'h0000_000F);

        // Reset mid-divide discards the pending result
        bus.Start = 1'b1; bus.MDUOP = 4'd3; bus.A = 32'd100; bus.B = 32'd3;
        tick();
        bus.Start = 1'b0; bus.MDUOP = 4'd0;
        tick();
        tick();
        tick();
        chk("rst_pre_busy", 32'(bus.Busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk_hilo("rst_mid", 32'd0, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("rst_late_busy", 32'(bus.Busy), 32'd0);
        chk_hilo("rst_late", 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
